// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port memory arbiter.
// Imported by the arbiter top and its round-robin picker.
package mem_arb_pkg;

  localparam int NPORTS = 2;
  localparam int WIDX_W = 30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin picker: a lone requester always wins,
// on a tie the port that was not granted last wins.
module mem_arb_rr
  import mem_arb_pkg::*;
(
  input  logic [NPORTS-1:0] pending,
  input  logic              last,
  output logic              grant,
  output logic              winner
);

  // Pick a winner from the pending set and the last-grant pointer
  always_comb begin
    grant  = |pending;
    winner = 1'b0;
    if (&pending) winner = ~last;
    else          winner = pending[1];
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter (m0 = CPU, m1 = DMA) with a fixed
// three-state IDLE -> ISSUE -> DONE flow and out-of-range detection.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_rstrb,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wmask,
  output logic [31:0]       m0_rdata,
  output logic              m0_done,
  output logic              m0_err,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_rstrb,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  output logic [31:0]       m1_rdata,
  output logic              m1_done,
  output logic              m1_err,
  output logic [31:0]       mem_addr,
  output logic              mem_rstrb,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
);

  state_t            state;
  logic              last;
  logic              gid;
  logic              grant;
  logic              winner;
  logic [NPORTS-1:0] pending;

  logic [ADDR_W-1:0] win_addr;
  logic [31:0]       win_wdata;
  logic [3:0]        win_wmask;
  logic              win_rstrb;

  logic [31:0]       cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wmask;
  logic              cmd_rd;

  logic [WIDX_W-1:0] widx;
  logic              oor;
  logic              in_issue;
  logic              in_done;
  logic [31:0]       done_rdata;
  logic [31:0]       hold0;
  logic [31:0]       hold1;

  assign pending = {m1_rstrb | (|m1_wmask),
                    m0_rstrb | (|m0_wmask)};

  mem_arb_rr u_rr (
    .pending (pending),
    .last    (last),
    .grant   (grant),
    .winner  (winner)
  );

  // Route the winning port's command toward the latch
  always_comb begin
    win_addr  = winner ? m1_addr  : m0_addr;
    win_wdata = winner ? m1_wdata : m0_wdata;
    win_wmask = winner ? m1_wmask : m0_wmask;
    win_rstrb = winner ? m1_rstrb : m0_rstrb;
  end

  // FSM plus command latch; pointer moves only on a grant
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      gid       <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_wmask <= '0;
      cmd_rd    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant) begin
            state     <= ISSUE;
            gid       <= winner;
            last      <= winner;
            cmd_addr  <= 32'(win_addr);
            cmd_wdata <= win_wdata;
            cmd_wmask <= win_wmask;
            cmd_rd    <= win_rstrb & ~(|win_wmask);
          end
        end
        ISSUE:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign widx     = cmd_addr[31:2];
  assign oor      = {2'b00, widx} >= 32'(MEM_WORDS);
  assign in_issue = (state == ISSUE);
  assign in_done  = (state == DONE);

  // Data returned in DONE: zero on error, memory data on reads
  always_comb begin
    done_rdata = gid ? hold1 : hold0;
    if (oor)         done_rdata = 32'h0;
    else if (cmd_rd) done_rdata = mem_rdata;
  end

  // Keep each port's rdata stable between its transactions
  always_ff @(posedge clk) begin
    if (reset) begin
      hold0 <= '0;
      hold1 <= '0;
    end else if (in_done) begin
      if (gid) hold1 <= done_rdata;
      else     hold0 <= done_rdata;
    end
  end

  // Memory side: strobes only in ISSUE and only in range
  always_comb begin
    mem_addr  = cmd_addr;
    mem_wdata = cmd_wdata;
    mem_rstrb = in_issue & cmd_rd & ~oor;
    mem_wmask = (in_issue && !oor) ? cmd_wmask : 4'h0;
  end

  // Requester side: one done pulse for the granted port
  always_comb begin
    m0_done  = in_done & ~gid;
    m1_done  = in_done & gid;
    m0_err   = m0_done & oor;
    m1_err   = m1_done & oor;
    m0_rdata = m0_done ? done_rdata : hold0;
    m1_rdata = m1_done ? done_rdata : hold1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous memory
// model; scenario tasks compare outputs against hand-computed values.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_rstrb, m1_rstrb;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wmask, m1_wmask;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_done, m1_done, m0_err, m1_err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;

  logic [31:0] mem [0:255];
  logic        pk_en = 1'b0;
  logic [7:0]  pk_idx = '0;
  logic [31:0] pk_val = '0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_WORDS(256), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_rstrb(m0_rstrb),
    .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_rstrb(m1_rstrb),
    .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
  );

  // Synchronous memory: data valid the cycle after mem_rstrb
  always @(posedge clk) begin
    if (pk_en) mem[pk_idx] <= pk_val;
    else begin
      if (mem_rstrb) mem_rdata <= mem[mem_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b])
          mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    m0_addr = '0; m0_rstrb = 0; m0_wdata = '0; m0_wmask = '0;
    m1_addr = '0; m1_rstrb = 0; m1_wdata = '0; m1_wmask = '0;
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] v);
    pk_en = 1; pk_idx = idx; pk_val = v;
    step();
    pk_en = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    idle_inputs();
    step(); step();
    checks++;
    if ({mem_rstrb, mem_wmask, m0_done, m1_done, m0_err, m1_err} !== 9'h0) begin
      failures++;
      $display("FAIL reset_ctl got %b want 0",
        {mem_rstrb, mem_wmask, m0_done, m1_done, m0_err, m1_err});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_mem got %h %h want 0", mem_addr, mem_wdata);
    end
    checks++;
    if ({m0_rdata, m1_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata got %h %h want 0", m0_rdata, m1_rdata);
    end
    reset = 0;
    step();
  endtask

  task automatic test_read();
    poke(8'd100, 32'h04030201);
    m0_addr = 32'd400; m0_rstrb = 1;
    step();
    checks++;
    if ({mem_rstrb, m0_done} !== 2'b10 || mem_addr !== 32'd400) begin
      failures++;
      $display("FAIL read_issue got rstrb=%b done=%b addr=%0d want 1 0 400",
        mem_rstrb, m0_done, mem_addr);
    end
    step();
    checks++;
    if ({m0_done, m0_err, m1_done} !== 3'b100) begin
      failures++;
      $display("FAIL read_done got %b want 100", {m0_done, m0_err, m1_done});
    end
    checks++;
    if (m0_rdata !== 32'h04030201) begin
      failures++;
      $display("FAIL read_data got %h want 04030201", m0_rdata);
    end
    idle_inputs();
    step();
    checks++;
    if (m0_done !== 1'b0 || m0_rdata !== 32'h04030201 || mem_rstrb !== 1'b0) begin
      failures++;
      $display("FAIL read_hold got done=%b rdata=%h rstrb=%b want 0 04030201 0",
        m0_done, m0_rdata, mem_rstrb);
    end
  endtask

  task automatic test_write();
    poke(8'd200, 32'h11223344);
    m1_addr = 32'd800; m1_wdata = 32'hAABBCCDD; m1_wmask = 4'b0010;
    step();
    checks++;
    if (mem_wmask !== 4'b0010 || mem_rstrb !== 1'b0 || mem_wdata !== 32'hAABBCCDD) begin
      failures++;
      $display("FAIL write_issue got wmask=%b rstrb=%b wdata=%h want 0010 0 aabbccdd",
        mem_wmask, mem_rstrb, mem_wdata);
    end
    step();
    checks++;
    if ({m1_done, m1_err, m0_done} !== 3'b100) begin
      failures++;
      $display("FAIL write_done got %b want 100", {m1_done, m1_err, m0_done});
    end
    checks++;
    if (mem[200] !== 32'h1122CC44) begin
      failures++;
      $display("FAIL write_byte got %h want 1122cc44", mem[200]);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_oor();
    m0_addr = 32'h400; m0_rstrb = 1;
    step();
    checks++;
    if ({mem_rstrb, mem_wmask} !== 5'b0) begin
      failures++;
      $display("FAIL oor_strobe got %b want 0", {mem_rstrb, mem_wmask});
    end
    step();
    checks++;
    if ({m0_done, m0_err} !== 2'b11 || m0_rdata !== 32'h0) begin
      failures++;
      $display("FAIL oor_done got done=%b err=%b rdata=%h want 1 1 0",
        m0_done, m0_err, m0_rdata);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int dual = 0;
    int first = -1;
    logic [3:0] who = '0;
    logic [31:0] rd [4];
    reset = 1;
    step();
    reset = 0;
    poke(8'd1, 32'h11110001);
    poke(8'd2, 32'h22220002);
    m0_addr = 32'd4; m0_rstrb = 1;
    m1_addr = 32'd8; m1_rstrb = 1;
    for (int c = 1; c <= 30 && n < 4; c++) begin
      step();
      if (m0_done && m1_done) dual++;
      if (m0_done || m1_done) begin
        if (first < 0) first = c;
        who[n] = m1_done;
        rd[n] = m1_done ? m1_rdata : m0_rdata;
        n++;
      end
    end
    idle_inputs();
    checks++;
    if (n !== 4) begin
      failures++;
      $display("FAIL rr_count got %0d want 4", n);
    end
    checks++;
    if (who !== 4'b1010) begin
      failures++;
      $display("FAIL rr_order got %b want 1010 (bit i = port of grant i)", who);
    end
    checks++;
    if (dual !== 0) begin
      failures++;
      $display("FAIL rr_dual got %0d want 0", dual);
    end
    checks++;
    if (first !== 2) begin
      failures++;
      $display("FAIL rr_latency got %0d want 2", first);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (rd[i] !== ((i % 2) ? 32'h22220002 : 32'h11110001)) begin
        failures++;
        $display("FAIL rr_data%0d got %h", i, rd[i]);
      end
    end
    step();
  endtask

  task automatic test_reset_mid();
    poke(8'd5, 32'h5A5A5A5A);
    m0_addr = 32'd20; m0_rstrb = 1;
    step();
    checks++;
    if (mem_rstrb !== 1'b1) begin
      failures++;
      $display("FAIL mid_issue got rstrb=%b want 1", mem_rstrb);
    end
    reset = 1;
    step();
    checks++;
    if ({mem_rstrb, mem_wmask, m0_done, m1_done} !== 7'b0) begin
      failures++;
      $display("FAIL mid_abort got %b want 0",
        {mem_rstrb, mem_wmask, m0_done, m1_done});
    end
    reset = 0;
    idle_inputs();
    step(); step();
    checks++;
    if ({m0_done, m1_done, mem_rstrb} !== 3'b0) begin
      failures++;
      $display("FAIL mid_quiet got %b want 0", {m0_done, m1_done, mem_rstrb});
    end
    m1_addr = 32'd20; m1_rstrb = 1;
    step();
    checks++;
    if (mem_rstrb !== 1'b1) begin
      failures++;
      $display("FAIL mid_reissue got rstrb=%b want 1", mem_rstrb);
    end
    step();
    checks++;
    if (m1_done !== 1'b1 || m1_rdata !== 32'h5A5A5A5A) begin
      failures++;
      $display("FAIL mid_redone got done=%b rdata=%h want 1 5a5a5a5a",
        m1_done, m1_rdata);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_write_rstrb();
    poke(8'd3, 32'h0);
    m0_addr = 32'd12; m0_rstrb = 1;
    m0_wdata = 32'hDEADBEEF; m0_wmask = 4'hF;
    step();
    checks++;
    if (mem_wmask !== 4'hF || mem_rstrb !== 1'b0) begin
      failures++;
      $display("FAIL wr_rd_issue got wmask=%h rstrb=%b want f 0",
        mem_wmask, mem_rstrb);
    end
    step();
    checks++;
    if (m0_done !== 1'b1 || mem_rstrb !== 1'b0) begin
      failures++;
      $display("FAIL wr_rd_done got done=%b rstrb=%b want 1 0",
        m0_done, mem_rstrb);
    end
    checks++;
    if (mem[3] !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_rd_mem got %h want deadbeef", mem[3]);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read();
    test_write();
    test_oor();
    test_back_to_back();
    test_reset_mid();
    test_write_rstrb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
